// File: rtl/crtc_reg_file.sv
// rtl/crtc_reg_file.sv - 6845-style CRTC register bank with CPU/Pi access and frame-synchronous shadowing
module crtc_reg_file #(
  parameter int          NUM_REGS    = 18,
  parameter logic [15:0] PI_BASE     = 16'hE8E0,
  parameter bit          SHADOW_EN   = 1'b1,
  parameter logic [31:0] SHADOW_MASK = 32'h000003FF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  crtc_select,
  input  logic [16:0]           bus_addr,
  input  logic [7:0]            bus_data_in,
  input  logic                  cpu_write,
  input  logic                  cpu_read,
  output logic [7:0]            cpu_data_out,
  output logic                  cpu_data_out_enable,
  input  logic [15:0]           pi_addr,
  input  logic [7:0]            pi_data_in,
  input  logic                  pi_read,
  input  logic                  pi_write,
  output logic [7:0]            pi_data_out,
  output logic                  pi_data_valid,
  input  logic                  frame_start,
  output logic [4:0]            crtc_address_register,
  output logic [7:0]            crtc_r,
  output logic [NUM_REGS*8-1:0] active_regs,
  output logic [NUM_REGS-1:0]   dirty
);

  function automatic logic [7:0] reg_mask(input int n);
    case (n)
      4, 6, 7, 10: return 8'h7F;
      5, 9, 11:    return 8'h1F;
      8:           return 8'h03;
      12, 14, 16:  return 8'h3F;
      default:     return 8'hFF;
    endcase
  endfunction

  logic [4:0]          r_addr;
  logic [7:0]          r_staged [NUM_REGS];
  logic [7:0]          r_active [NUM_REGS];
  logic [NUM_REGS-1:0] r_dirty;
  logic [NUM_REGS-1:0] r_pending;
  logic [7:0]          r_cpu_data;
  logic                r_cpu_en;
  logic [7:0]          r_pi_data;
  logic                r_pi_valid;

  logic                w_rs;
  logic [4:0]          w_pi_idx;
  logic                w_pi_hit;
  logic                w_addr_valid;
  logic                w_pi_idx_valid;
  logic                w_cpu_data_wr;
  logic                w_cpu_sel_wr;
  logic                w_cpu_rd;
  logic                w_pi_rd;
  logic [7:0]          w_active_sel;
  logic [7:0]          w_staged_pi;
  logic [7:0]          w_cpu_rdata;
  logic [NUM_REGS-1:0] w_cpu_wr_vec;
  logic [NUM_REGS-1:0] w_pi_wr_vec;
  logic [NUM_REGS-1:0] w_pi_rd_vec;
  logic [NUM_REGS-1:0] w_shadowed;
  logic                w_unused;

  assign w_rs     = bus_addr[0];
  assign w_unused = ^bus_addr[16:1];
  assign w_pi_idx = pi_addr[4:0];
  assign w_pi_hit = (pi_addr[15:5] == PI_BASE[15:5]);

  // Register decode done by loop compare so out-of-range indices simply match nothing.
  always_comb begin
    w_addr_valid   = 1'b0;
    w_pi_idx_valid = 1'b0;
    w_active_sel   = 8'h00;
    w_staged_pi    = 8'h00;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (r_addr == 5'(n)) begin
        w_addr_valid = 1'b1;
        w_active_sel = r_active[n];
      end
      if (w_pi_idx == 5'(n)) begin
        w_pi_idx_valid = 1'b1;
        w_staged_pi    = r_staged[n];
      end
    end
  end

  assign w_cpu_sel_wr  = cpu_write & crtc_select & ~w_rs;
  assign w_cpu_data_wr = cpu_write & crtc_select & w_rs & w_addr_valid
                         & (r_addr != 5'd16) & (r_addr != 5'd17);
  assign w_cpu_rd      = cpu_read & crtc_select & w_rs;
  assign w_pi_rd       = pi_read & w_pi_hit;
  assign w_cpu_rdata   = (r_addr >= 5'd14 && r_addr <= 5'd17) ? w_active_sel : 8'h00;

  always_comb begin
    w_cpu_wr_vec = '0;
    w_pi_wr_vec  = '0;
    w_pi_rd_vec  = '0;
    w_shadowed   = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      w_cpu_wr_vec[n] = w_cpu_data_wr && (r_addr == 5'(n));
      // CPU beats Pi on a same-cycle write to the same register.
      w_pi_wr_vec[n]  = pi_write && w_pi_hit && w_pi_idx_valid && (w_pi_idx == 5'(n))
                        && !w_cpu_wr_vec[n];
      w_pi_rd_vec[n]  = w_pi_rd && (w_pi_idx == 5'(n));
      w_shadowed[n]   = SHADOW_EN && SHADOW_MASK[n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_dirty    <= '0;
      r_pending  <= '0;
      r_cpu_data <= '0;
      r_cpu_en   <= 1'b0;
      r_pi_data  <= '0;
      r_pi_valid <= 1'b0;
      for (int n = 0; n < NUM_REGS; n++) begin
        r_staged[n] <= '0;
        r_active[n] <= '0;
      end
    end else begin
      if (w_cpu_sel_wr) r_addr <= bus_data_in[4:0];

      for (int n = 0; n < NUM_REGS; n++) begin
        if (w_cpu_wr_vec[n])     r_staged[n] <= bus_data_in & reg_mask(n);
        else if (w_pi_wr_vec[n]) r_staged[n] <= pi_data_in & reg_mask(n);

        // A commit coinciding with a CPU write takes the pre-edge staged value.
        if (w_cpu_wr_vec[n] && !w_shadowed[n])   r_active[n] <= bus_data_in & reg_mask(n);
        else if (w_pi_wr_vec[n])                 r_active[n] <= pi_data_in & reg_mask(n);
        else if (frame_start && r_pending[n])    r_active[n] <= r_staged[n];

        if (w_cpu_wr_vec[n] && w_shadowed[n])    r_pending[n] <= 1'b1;
        else if (w_pi_wr_vec[n] || frame_start)  r_pending[n] <= 1'b0;

        if (w_cpu_wr_vec[n])                     r_dirty[n] <= 1'b1;
        else if (w_pi_rd_vec[n])                 r_dirty[n] <= 1'b0;
      end

      r_cpu_en   <= w_cpu_rd;
      r_cpu_data <= w_cpu_rd ? w_cpu_rdata : 8'h00;
      r_pi_valid <= w_pi_rd;
      r_pi_data  <= w_pi_rd ? w_staged_pi : 8'h00;
    end
  end

  always_comb begin
    active_regs = '0;
    for (int n = 0; n < NUM_REGS; n++) active_regs[n*8 +: 8] = r_active[n];
  end

  assign crtc_address_register = r_addr;
  assign crtc_r                = w_active_sel;
  assign dirty                 = r_dirty;
  assign cpu_data_out          = r_cpu_data;
  assign cpu_data_out_enable   = r_cpu_en;
  assign pi_data_out           = r_pi_data;
  assign pi_data_valid         = r_pi_valid;

endmodule
